// File: rtl/nts_timestamp.sv
// NTS response timestamper: captures receive/transmit times and parser fields, then
// streams a six-word big-endian NTP header; small 32-bit register file on the API bus.
module nts_timestamp (
    input  logic        i_clk,
    input  logic        i_areset,
    input  logic [63:0] i_ntp_time,
    input  logic        i_parser_clear,
    input  logic        i_parser_record_receive_timestamp,
    input  logic        i_parser_transmit,
    input  logic [63:0] i_parser_origin_timestamp,
    input  logic [2:0]  i_parser_version_number,
    input  logic [7:0]  i_parser_poll,
    output logic        o_tx_wr_en,
    output logic [2:0]  o_tx_ntp_header_block,
    output logic [63:0] o_tx_ntp_header_data,
    input  logic        i_api_cs,
    input  logic        i_api_we,
    input  logic [7:0]  i_api_address,
    input  logic [31:0] i_api_write_data,
    output logic [31:0] o_api_read_data
);
    localparam logic [7:0] ADDR_NAME0      = 8'h00;
    localparam logic [7:0] ADDR_NAME1      = 8'h01;
    localparam logic [7:0] ADDR_CONFIG     = 8'h10;
    localparam logic [7:0] ADDR_ROOT_DELAY = 8'h11;
    localparam logic [7:0] ADDR_ROOT_DISP  = 8'h12;
    localparam logic [7:0] ADDR_REF_ID     = 8'h13;
    localparam logic [7:0] ADDR_TX_OFS     = 8'h14;
    localparam logic [2:0] LAST_BLOCK      = 3'd5;

    typedef enum logic {IDLE, TX} state_t;

    state_t      state, state_nx;
    logic [2:0]  blk, blk_nx;
    logic        capture, record;

    logic [31:0] cfg, root_delay, root_disp, ref_id, tx_ofs;
    logic [63:0] rx_ts, origin, tx_ts;
    logic [31:0] ref_sec;
    logic [2:0]  vn;
    logic [7:0]  poll;

    always_ff @(posedge i_clk or negedge i_areset) begin
        if (!i_areset) begin
            state <= IDLE;
            blk   <= '0;
        end else begin
            state <= state_nx;
            blk   <= blk_nx;
        end
    end

    // Header words are muxed straight from the holding registers, so an API write
    // during a transmission shows up on the very next word.
    always_comb begin
        state_nx              = state;
        blk_nx                = blk;
        capture               = 1'b0;
        record                = 1'b0;
        o_tx_wr_en            = 1'b0;
        o_tx_ntp_header_block = '0;
        o_tx_ntp_header_data  = '0;
        if (i_parser_clear) begin
            state_nx = IDLE;
            blk_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    record = i_parser_record_receive_timestamp;
                    if (i_parser_transmit) begin
                        capture  = 1'b1;
                        state_nx = TX;
                        blk_nx   = '0;
                    end
                end
                TX: begin
                    if (blk == LAST_BLOCK) begin
                        state_nx = IDLE;
                        blk_nx   = '0;
                    end else begin
                        blk_nx = blk + 3'd1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    blk_nx   = '0;
                end
            endcase
        end
        if (state == TX) begin
            o_tx_wr_en            = 1'b1;
            o_tx_ntp_header_block = blk;
            case (blk)
                3'd0:    o_tx_ntp_header_data = {cfg[9:8], vn, 3'd4, 8'h01, poll, cfg[7:0], root_delay};
                3'd1:    o_tx_ntp_header_data = {root_disp, ref_id};
                3'd2:    o_tx_ntp_header_data = {ref_sec, 32'h0};
                3'd3:    o_tx_ntp_header_data = origin;
                3'd4:    o_tx_ntp_header_data = rx_ts;
                3'd5:    o_tx_ntp_header_data = tx_ts;
                default: o_tx_ntp_header_data = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_areset) begin
        if (!i_areset) begin
            rx_ts   <= '0;
            origin  <= '0;
            tx_ts   <= '0;
            ref_sec <= '0;
            vn      <= '0;
            poll    <= '0;
        end else if (i_parser_clear) begin
            rx_ts  <= '0;
            origin <= '0;
            vn     <= '0;
            poll   <= '0;
        end else begin
            if (record) rx_ts <= i_ntp_time;
            if (capture) begin
                origin  <= i_parser_origin_timestamp;
                vn      <= i_parser_version_number;
                poll    <= i_parser_poll;
                tx_ts   <= i_ntp_time + {32'h0, tx_ofs};
                ref_sec <= i_ntp_time[63:32] - 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_areset) begin
        if (!i_areset) begin
            cfg        <= '0;
            root_delay <= '0;
            root_disp  <= '0;
            ref_id     <= '0;
            tx_ofs     <= '0;
        end else if (i_api_cs && i_api_we) begin
            case (i_api_address)
                ADDR_CONFIG:     cfg        <= i_api_write_data;
                ADDR_ROOT_DELAY: root_delay <= i_api_write_data;
                ADDR_ROOT_DISP:  root_disp  <= i_api_write_data;
                ADDR_REF_ID:     ref_id     <= i_api_write_data;
                ADDR_TX_OFS:     tx_ofs     <= i_api_write_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_areset) begin
        if (!i_areset) begin
            o_api_read_data <= '0;
        end else if (i_api_cs && !i_api_we) begin
            case (i_api_address)
                ADDR_NAME0:      o_api_read_data <= 32'h74696d65;
                ADDR_NAME1:      o_api_read_data <= 32'h73746d70;
                ADDR_CONFIG:     o_api_read_data <= cfg;
                ADDR_ROOT_DELAY: o_api_read_data <= root_delay;
                ADDR_ROOT_DISP:  o_api_read_data <= root_disp;
                ADDR_REF_ID:     o_api_read_data <= ref_id;
                ADDR_TX_OFS:     o_api_read_data <= tx_ofs;
                default:         o_api_read_data <= '0;
            endcase
        end else begin
            o_api_read_data <= '0;
        end
    end
endmodule

// File: tb/tb_nts_timestamp.sv
// Self-checking bench for nts_timestamp: literal-value scenarios plus randomized
// request streams compared against a transaction-level reference model.
module tb_nts_timestamp;
    logic        i_clk = 1'b0;
    logic        i_areset;
    logic [63:0] i_ntp_time;
    logic        i_parser_clear, i_parser_record_receive_timestamp, i_parser_transmit;
    logic [63:0] i_parser_origin_timestamp;
    logic [2:0]  i_parser_version_number;
    logic [7:0]  i_parser_poll;
    logic        o_tx_wr_en;
    logic [2:0]  o_tx_ntp_header_block;
    logic [63:0] o_tx_ntp_header_data;
    logic        i_api_cs, i_api_we;
    logic [7:0]  i_api_address;
    logic [31:0] i_api_write_data;
    logic [31:0] o_api_read_data;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    nts_timestamp dut (
        .i_clk(i_clk), .i_areset(i_areset), .i_ntp_time(i_ntp_time),
        .i_parser_clear(i_parser_clear),
        .i_parser_record_receive_timestamp(i_parser_record_receive_timestamp),
        .i_parser_transmit(i_parser_transmit),
        .i_parser_origin_timestamp(i_parser_origin_timestamp),
        .i_parser_version_number(i_parser_version_number), .i_parser_poll(i_parser_poll),
        .o_tx_wr_en(o_tx_wr_en), .o_tx_ntp_header_block(o_tx_ntp_header_block),
        .o_tx_ntp_header_data(o_tx_ntp_header_data),
        .i_api_cs(i_api_cs), .i_api_we(i_api_we), .i_api_address(i_api_address),
        .i_api_write_data(i_api_write_data), .o_api_read_data(o_api_read_data)
    );

    // Reference model: packet fields, registers, and which header word is on the bus (-1 = none)
    logic [31:0] m_cfg, m_rdelay, m_rdisp, m_refid, m_txofs, m_refsec, m_rd;
    logic [63:0] m_rx, m_origin, m_txts;
    logic [2:0]  m_vn;
    logic [7:0]  m_poll;
    int          m_idx;

    function automatic logic [31:0] api_val(input logic [7:0] a);
        case (a)
            8'h00: return 32'h74696d65;
            8'h01: return 32'h73746d70;
            8'h10: return m_cfg;
            8'h11: return m_rdelay;
            8'h12: return m_rdisp;
            8'h13: return m_refid;
            8'h14: return m_txofs;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [63:0] exp_data();
        case (m_idx)
            0: return {m_cfg[9:8], m_vn, 3'd4, 8'h01, m_poll, m_cfg[7:0], m_rdelay};
            1: return {m_rdisp, m_refid};
            2: return {m_refsec, 32'h0};
            3: return m_origin;
            4: return m_rx;
            5: return m_txts;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [2:0] exp_blk();
        return (m_idx >= 0) ? 3'(m_idx) : 3'd0;
    endfunction

    task automatic model_reset();
        {m_cfg, m_rdelay, m_rdisp, m_refid, m_txofs, m_refsec, m_rd} = '0;
        {m_rx, m_origin, m_txts} = '0;
        m_vn = '0; m_poll = '0; m_idx = -1;
    endtask

    task automatic model_edge();
        logic [31:0] nrd;
        nrd = (i_api_cs && !i_api_we) ? api_val(i_api_address) : 32'h0;
        if (i_parser_clear) begin
            m_rx = '0; m_origin = '0; m_vn = '0; m_poll = '0; m_idx = -1;
        end else if (m_idx >= 0) begin
            m_idx = (m_idx == 5) ? -1 : m_idx + 1;
        end else begin
            if (i_parser_record_receive_timestamp) m_rx = i_ntp_time;
            if (i_parser_transmit) begin
                m_origin = i_parser_origin_timestamp;
                m_vn     = i_parser_version_number;
                m_poll   = i_parser_poll;
                m_txts   = i_ntp_time + {32'h0, m_txofs};
                m_refsec = i_ntp_time[63:32] - 32'd1;
                m_idx    = 0;
            end
        end
        if (i_api_cs && i_api_we) begin
            case (i_api_address)
                8'h10: m_cfg    = i_api_write_data;
                8'h11: m_rdelay = i_api_write_data;
                8'h12: m_rdisp  = i_api_write_data;
                8'h13: m_refid  = i_api_write_data;
                8'h14: m_txofs  = i_api_write_data;
                default: ;
            endcase
        end
        m_rd = nrd;
    endtask

    // One clock: model follows the edge, outputs settle by the falling edge, pulses drop.
    task automatic tick();
        model_edge();
        @(posedge i_clk);
        @(negedge i_clk);
        i_parser_transmit = 1'b0;
        i_parser_record_receive_timestamp = 1'b0;
        i_parser_clear = 1'b0;
        i_api_cs = 1'b0;
        i_api_we = 1'b0;
        i_ntp_time = i_ntp_time + 64'($urandom_range(1, 5000));
    endtask

    task automatic api_write(input logic [7:0] a, input logic [31:0] d);
        i_api_cs = 1'b1; i_api_we = 1'b1; i_api_address = a; i_api_write_data = d;
        tick();
    endtask

    task automatic api_read(input logic [7:0] a);
        i_api_cs = 1'b1; i_api_we = 1'b0; i_api_address = a;
        tick();
    endtask

    task automatic request(input logic [63:0] org, input logic [2:0] v, input logic [7:0] p);
        i_parser_transmit = 1'b1;
        i_parser_origin_timestamp = org;
        i_parser_version_number = v;
        i_parser_poll = p;
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && m_idx >= 0; i++) tick();
    endtask

    task automatic test_reset();
        i_areset = 1'b0;
        #23;
        if ({o_tx_wr_en, o_tx_ntp_header_block, o_tx_ntp_header_data, o_api_read_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: wr=%b blk=%0d data=%h rd=%h, required all zero",
                     o_tx_wr_en, o_tx_ntp_header_block, o_tx_ntp_header_data, o_api_read_data);
        end
        checks++;
        model_reset();
        @(negedge i_clk);
        i_areset = 1'b1;
        tick();
        if (o_api_read_data !== 32'h0) begin
            errors++; $display("FAIL idle_read: got %h, required 0", o_api_read_data);
        end
        checks++;
        if (o_tx_wr_en !== 1'b0) begin
            errors++; $display("FAIL idle_wr_en: got %b, required 0", o_tx_wr_en);
        end
        checks++;
    endtask

    task automatic test_names();
        logic [7:0]  addrs [3] = '{8'h00, 8'h01, 8'h55};
        logic [31:0] exps  [3] = '{32'h74696d65, 32'h73746d70, 32'h0};
        for (int i = 0; i < 3; i++) begin
            api_read(addrs[i]);
            if (o_api_read_data !== exps[i]) begin
                errors++;
                $display("FAIL name_read[%h]: got %h, required %h", addrs[i], o_api_read_data, exps[i]);
            end
            checks++;
        end
        tick();
        if (o_api_read_data !== 32'h0) begin
            errors++; $display("FAIL read_after_idle: got %h, required 0", o_api_read_data);
        end
        checks++;
    endtask

    task automatic test_regs();
        logic [31:0] vals [5] = '{32'hdeadbeef, 32'h1007de1a, 32'h1007d155, 32'habad1dea, 32'hc01df00d};
        for (int i = 0; i < 5; i++) api_write(8'h10 + 8'(i), vals[i]);
        for (int i = 0; i < 5; i++) begin
            api_read(8'h10 + 8'(i));
            if (o_api_read_data !== vals[i]) begin
                errors++;
                $display("FAIL reg_readback[%h]: got %h, required %h", 8'h10 + 8'(i), o_api_read_data, vals[i]);
            end
            checks++;
        end
    endtask

    task automatic test_full_header();
        logic [63:0] rec_t, tx_t, org;
        logic [63:0] want [6];
        api_write(8'h10, 32'h0);
        api_write(8'h14, 32'h0);
        api_write(8'h11, 32'h1007de1a);
        api_write(8'h12, 32'h1007d155);
        api_write(8'h13, 32'habad1dea);
        i_parser_record_receive_timestamp = 1'b1;
        tick();
        i_parser_record_receive_timestamp = 1'b1;
        rec_t = i_ntp_time;
        tick();
        tx_t = {32'hffffeeee, $urandom};
        i_ntp_time = tx_t;
        org = {$urandom, $urandom};
        want = '{64'h040100001007de1a, 64'h1007d155abad1dea, 64'hffffeeed00000000, org, rec_t, tx_t};
        request(org, 3'd0, 8'h00);
        for (int b = 0; b < 6; b++) begin
            if (o_tx_wr_en !== 1'b1 || o_tx_ntp_header_block !== 3'(b) || o_tx_ntp_header_data !== want[b]) begin
                errors++;
                $display("FAIL full_header[%0d]: wr=%b blk=%0d data=%h, required wr=1 blk=%0d data=%h",
                         b, o_tx_wr_en, o_tx_ntp_header_block, o_tx_ntp_header_data, b, want[b]);
            end
            checks++;
            tick();
        end
        if (o_tx_wr_en !== 1'b0 || o_tx_ntp_header_data !== 64'h0) begin
            errors++;
            $display("FAIL full_header_end: wr=%b data=%h, required 0/0", o_tx_wr_en, o_tx_ntp_header_data);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int words;
        for (int s = 0; s < 10; s++) begin
            if ($urandom_range(0, 1) == 1) api_write(8'h14, $urandom);
            i_parser_record_receive_timestamp = 1'($urandom_range(0, 1));
            request({$urandom, $urandom}, 3'($urandom), 8'($urandom));
            words = 0;
            for (int c = 0; c < 7; c++) begin
                if (o_tx_wr_en !== (m_idx >= 0) || o_tx_ntp_header_block !== exp_blk()
                    || o_tx_ntp_header_data !== exp_data()) begin
                    errors++;
                    $display("FAIL b2b[%0d.%0d]: wr=%b blk=%0d data=%h, required wr=%b blk=%0d data=%h",
                             s, c, o_tx_wr_en, o_tx_ntp_header_block, o_tx_ntp_header_data,
                             m_idx >= 0, exp_blk(), exp_data());
                end
                checks++;
                if (o_tx_wr_en === 1'b1) words++;
                if (c <= 5) begin
                    // noise during TX: ignored requests/records, plus live register writes
                    i_parser_transmit = 1'($urandom_range(0, 1));
                    i_parser_record_receive_timestamp = 1'($urandom_range(0, 1));
                    i_parser_origin_timestamp = {$urandom, $urandom};
                    if ($urandom_range(0, 2) == 0) begin
                        i_api_cs = 1'b1; i_api_we = 1'b1;
                        i_api_address = 8'h10 + 8'($urandom_range(0, 4));
                        i_api_write_data = $urandom;
                    end
                end
                tick();
            end
            if (words != 6) begin
                errors++; $display("FAIL b2b_count[%0d]: got %0d words, required 6", s, words);
            end
            checks++;
        end
        drain();
    endtask

    task automatic test_offset_config();
        logic [63:0] tx_t;
        logic [2:0]  v;
        api_write(8'h14, 32'h10);
        api_write(8'h10, 32'h2e9);
        v = 3'($urandom);
        tx_t = i_ntp_time;
        request({$urandom, $urandom}, v, 8'($urandom));
        if (o_tx_ntp_header_data[63:56] !== {2'b10, v, 3'b100} || o_tx_ntp_header_data[39:32] !== 8'he9) begin
            errors++;
            $display("FAIL cfg2e9_block0: byte0=%h prec=%h, required %h/e9",
                     o_tx_ntp_header_data[63:56], o_tx_ntp_header_data[39:32], {2'b10, v, 3'b100});
        end
        checks++;
        for (int i = 0; i < 5; i++) tick();
        if (o_tx_ntp_header_block !== 3'd5 || o_tx_ntp_header_data !== tx_t + 64'h10) begin
            errors++;
            $display("FAIL tx_offset: blk=%0d data=%h, required 5/%h",
                     o_tx_ntp_header_block, o_tx_ntp_header_data, tx_t + 64'h10);
        end
        checks++;
        drain();
        api_write(8'h10, 32'h3e9);
        request({$urandom, $urandom}, 3'd0, 8'h00);
        if (o_tx_ntp_header_data[63:56] !== 8'hc4 || o_tx_ntp_header_data[39:32] !== 8'he9) begin
            errors++;
            $display("FAIL cfg3e9_block0: byte0=%h prec=%h, required c4/e9",
                     o_tx_ntp_header_data[63:56], o_tx_ntp_header_data[39:32]);
        end
        checks++;
        drain();
    endtask

    task automatic test_clear();
        i_parser_record_receive_timestamp = 1'b1;
        tick();
        request({$urandom, $urandom}, 3'd5, 8'h11);
        tick();
        tick();
        if (o_tx_ntp_header_block !== 3'd2 || o_tx_wr_en !== 1'b1) begin
            errors++; $display("FAIL clear_setup: blk=%0d wr=%b, required 2/1", o_tx_ntp_header_block, o_tx_wr_en);
        end
        checks++;
        i_parser_clear = 1'b1;
        tick();
        if (o_tx_wr_en !== 1'b0 || o_tx_ntp_header_data !== 64'h0) begin
            errors++; $display("FAIL clear_abort: wr=%b data=%h, required 0/0", o_tx_wr_en, o_tx_ntp_header_data);
        end
        checks++;
        // clear also beats a simultaneous request
        i_parser_clear = 1'b1;
        i_parser_transmit = 1'b1;
        tick();
        if (o_tx_wr_en !== 1'b0) begin
            errors++; $display("FAIL clear_priority: wr=%b, required 0", o_tx_wr_en);
        end
        checks++;
        request(64'h0, 3'd0, 8'h00);
        for (int i = 0; i < 3; i++) tick();
        if (o_tx_ntp_header_block !== 3'd3 || o_tx_ntp_header_data !== 64'h0) begin
            errors++; $display("FAIL clear_origin: blk=%0d data=%h, required 3/0", o_tx_ntp_header_block, o_tx_ntp_header_data);
        end
        checks++;
        tick();
        if (o_tx_ntp_header_block !== 3'd4 || o_tx_ntp_header_data !== 64'h0) begin
            errors++; $display("FAIL clear_rx: blk=%0d data=%h, required 4/0", o_tx_ntp_header_block, o_tx_ntp_header_data);
        end
        checks++;
        drain();
    endtask

    task automatic test_reset_mid_tx();
        api_write(8'h11, 32'h12345678);
        request({$urandom, $urandom}, 3'd4, 8'h06);
        tick();
        #2 i_areset = 1'b0;
        #1;
        if ({o_tx_wr_en, o_tx_ntp_header_block, o_tx_ntp_header_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid_tx: wr=%b blk=%0d data=%h, required all zero",
                     o_tx_wr_en, o_tx_ntp_header_block, o_tx_ntp_header_data);
        end
        checks++;
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        i_areset = 1'b1;
        request({$urandom, $urandom}, 3'($urandom), 8'($urandom));
        for (int c = 0; c < 7; c++) begin
            if (o_tx_wr_en !== (m_idx >= 0) || o_tx_ntp_header_block !== exp_blk()
                || o_tx_ntp_header_data !== exp_data()) begin
                errors++;
                $display("FAIL post_reset_tx[%0d]: wr=%b blk=%0d data=%h, required wr=%b blk=%0d data=%h",
                         c, o_tx_wr_en, o_tx_ntp_header_block, o_tx_ntp_header_data,
                         m_idx >= 0, exp_blk(), exp_data());
            end
            checks++;
            tick();
        end
        api_read(8'h11);
        if (o_api_read_data !== 32'h0) begin
            errors++; $display("FAIL reset_clears_reg: got %h, required 0", o_api_read_data);
        end
        checks++;
    endtask

    initial begin
        i_ntp_time = {$urandom, $urandom};
        i_parser_clear = 1'b0;
        i_parser_record_receive_timestamp = 1'b0;
        i_parser_transmit = 1'b0;
        i_parser_origin_timestamp = '0;
        i_parser_version_number = '0;
        i_parser_poll = '0;
        i_api_cs = 1'b0;
        i_api_we = 1'b0;
        i_api_address = '0;
        i_api_write_data = '0;
        model_reset();
        test_reset();
        test_names();
        test_regs();
        test_full_header();
        test_back_to_back();
        test_offset_config();
        test_clear();
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end
endmodule
